// File: rtl/aud_rec_sram_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : aud_rec_sram_writer_if
// Purpose  : Write-side SRAM pin bundle between the record writer and the
//            top-level SRAM pin mux.
// Revision : 1.0 - initial release
// ============================================================================
interface aud_rec_sram_writer_if;
    logic [19:0] o_SRAM_ADDR;
    logic [15:0] o_SRAM_DQ;
    logic        o_SRAM_DQ_OE;
    logic        o_SRAM_WE_N;
    logic        o_SRAM_CE_N;
    logic        o_SRAM_OE_N;
    logic        o_SRAM_LB_N;
    logic        o_SRAM_UB_N;

    modport master (
        output o_SRAM_ADDR, o_SRAM_DQ, o_SRAM_DQ_OE,
        output o_SRAM_WE_N, o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_LB_N, o_SRAM_UB_N
    );

    modport slave (
        input  o_SRAM_ADDR, o_SRAM_DQ, o_SRAM_DQ_OE,
        input  o_SRAM_WE_N, o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_LB_N, o_SRAM_UB_N
    );
endinterface
`default_nettype wire

// File: rtl/aud_rec_sram_writer.sv
`default_nettype none
// ============================================================================
// Module   : aud_rec_sram_writer
// Purpose  : Captures left-channel I2S ADC samples and writes one 16-bit word
//            per frame into external SRAM, with start/pause/stop control.
// Revision : 1.0 - initial release
// ============================================================================
module aud_rec_sram_writer #(
    parameter logic [19:0] ADDR_BASE   = 20'h00000,
    parameter logic [19:0] REC_LEN     = 20'h20000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic                   i_pause,
    input  logic                   i_stop,
    input  logic                   i_AUD_BCLK,
    input  logic                   i_AUD_ADCLRCK,
    input  logic                   i_AUD_ADCDAT,
    aud_rec_sram_writer_if.master  sram,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [19:0]            o_rec_len
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT_L = 3'd1,
        S_SHIFT  = 3'd2,
        S_W0     = 3'd3,
        S_W1     = 3'd4,
        S_W2     = 3'd5,
        S_PAUSED = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    // Bit order inside the synchroniser word: {adcdat, adclrck, bclk}
    logic [2:0]  w_async;
    logic [2:0]  r_sync [SYNC_STAGES];
    logic [2:0]  w_sync;
    logic [1:0]  r_prev;
    logic        w_bclk_rise;
    logic        w_lrck_fall;
    logic        w_lrck_rise;
    logic        w_dat;

    state_t      r_state;
    state_t      w_next;
    logic        w_writing_next;

    logic [15:0] r_shift;
    logic [15:0] w_shift_next;
    logic [4:0]  r_bitcnt;
    logic        r_skip;
    logic        r_pause_pend;
    logic        r_stop_pend;
    logic [19:0] r_wr_addr;
    logic [19:0] r_rec_len;
    logic [19:0] w_len_inc;

    logic [15:0] r_dq;
    logic        r_dq_oe;
    logic        r_we_n;
    logic        r_busy;
    logic        r_done;

    assign w_async      = {i_AUD_ADCDAT, i_AUD_ADCLRCK, i_AUD_BCLK};
    assign w_sync       = r_sync[SYNC_STAGES-1];
    assign w_bclk_rise  =  w_sync[0] & ~r_prev[0];
    assign w_lrck_fall  = ~w_sync[1] &  r_prev[1];
    assign w_lrck_rise  =  w_sync[1] & ~r_prev[1];
    assign w_dat        =  w_sync[2];
    assign w_shift_next = {r_shift[14:0], w_dat};
    assign w_len_inc    = r_rec_len + 20'd1;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_next = S_WAIT_L;
            end
            S_WAIT_L: begin
                if (i_stop)           w_next = S_DONE;
                else if (i_pause)     w_next = S_PAUSED;
                else if (w_lrck_fall) w_next = S_SHIFT;
            end
            S_SHIFT: begin
                // A right-channel LRCK edge before the 16th bit means a short frame
                if (i_stop)           w_next = S_DONE;
                else if (i_pause)     w_next = S_PAUSED;
                else if (w_lrck_rise) w_next = S_WAIT_L;
                else if (w_bclk_rise && !r_skip && (r_bitcnt == 5'd15))
                                      w_next = S_W0;
            end
            S_W0: w_next = S_W1;
            S_W1: w_next = S_W2;
            S_W2: begin
                if (i_stop || r_stop_pend)        w_next = S_DONE;
                else if (w_len_inc == REC_LEN)    w_next = S_DONE;
                else if (i_pause || r_pause_pend) w_next = S_PAUSED;
                else                              w_next = S_WAIT_L;
            end
            S_PAUSED: begin
                if (i_stop)       w_next = S_DONE;
                else if (i_pause) w_next = S_WAIT_L;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_writing_next = (w_next == S_W0) || (w_next == S_W1) || (w_next == S_W2);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 3'b000;
            r_prev       <= 2'b00;
            r_state      <= S_IDLE;
            r_shift      <= 16'h0000;
            r_bitcnt     <= 5'd0;
            r_skip       <= 1'b0;
            r_pause_pend <= 1'b0;
            r_stop_pend  <= 1'b0;
            r_wr_addr    <= ADDR_BASE;
            r_rec_len    <= 20'd0;
            r_dq         <= 16'h0000;
            r_dq_oe      <= 1'b0;
            r_we_n       <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_sync[0] <= w_async;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_prev  <= w_sync[1:0];
            r_state <= w_next;

            if (r_state == S_IDLE && i_start) begin
                r_wr_addr <= ADDR_BASE;
                r_rec_len <= 20'd0;
            end

            if (r_state == S_WAIT_L && w_next == S_SHIFT) begin
                r_skip   <= 1'b1;
                r_bitcnt <= 5'd0;
            end else if (r_state == S_SHIFT && w_bclk_rise) begin
                if (r_skip) begin
                    r_skip <= 1'b0;
                end else begin
                    r_shift  <= w_shift_next;
                    r_bitcnt <= r_bitcnt + 5'd1;
                end
            end

            // Pause/stop seen mid-write are held until the hold cycle finishes
            if (r_state == S_W0 || r_state == S_W1) begin
                if (i_pause) r_pause_pend <= 1'b1;
                if (i_stop)  r_stop_pend  <= 1'b1;
            end else if (r_state == S_W2) begin
                r_pause_pend <= 1'b0;
                r_stop_pend  <= 1'b0;
                r_wr_addr    <= r_wr_addr + 20'd1;
                r_rec_len    <= w_len_inc;
            end

            if (r_state == S_SHIFT && w_next == S_W0) r_dq <= w_shift_next;
            else if (!w_writing_next)                 r_dq <= 16'h0000;

            r_dq_oe <= w_writing_next;
            r_we_n  <= (w_next != S_W1);
            r_busy  <= (w_next != S_IDLE) && (w_next != S_DONE);
            r_done  <= (w_next == S_DONE);
        end
    end

    assign sram.o_SRAM_ADDR  = r_wr_addr;
    assign sram.o_SRAM_DQ    = r_dq;
    assign sram.o_SRAM_DQ_OE = r_dq_oe;
    assign sram.o_SRAM_WE_N  = r_we_n;
    assign sram.o_SRAM_CE_N  = 1'b0;
    assign sram.o_SRAM_OE_N  = 1'b1;
    assign sram.o_SRAM_LB_N  = 1'b0;
    assign sram.o_SRAM_UB_N  = 1'b0;

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_rec_len = r_rec_len;

endmodule
`default_nettype wire

// File: tb/tb_aud_rec_sram_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_aud_rec_sram_writer
// Purpose  : Self-checking bench: I2S frame generator, SRAM write monitor and
//            a take-level reference model of what should land in memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aud_rec_sram_writer;

    localparam logic [19:0] c_REC_LEN = 20'd4;

    logic        clk;
    logic        rst_n;
    logic        start, pause, stop;
    logic        bclk, lrck, dat;
    logic        busy, done;
    logic [19:0] rec_len;

    aud_rec_sram_writer_if sram ();

    aud_rec_sram_writer #(
        .ADDR_BASE   (20'h00000),
        .REC_LEN     (c_REC_LEN),
        .SYNC_STAGES (2)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_pause       (pause),
        .i_stop        (stop),
        .i_AUD_BCLK    (bclk),
        .i_AUD_ADCLRCK (lrck),
        .i_AUD_ADCDAT  (dat),
        .sram          (sram),
        .o_busy        (busy),
        .o_done        (done),
        .o_rec_len     (rec_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // ---------------- SRAM write monitor ----------------
    logic [15:0] mem     [0:255];
    bit          written [0:255];
    int unsigned cyc = 0, wr_total = 0, done_cnt = 0, wr_at_done = 0;
    int unsigned we_cyc = 0, done_cyc = 0, we_run = 0, oe_run = 0;
    int unsigned last_we_len = 0, last_oe_len = 0, bad_strobe = 0, bad_done = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (sram.o_SRAM_WE_N === 1'b0) begin
            mem[sram.o_SRAM_ADDR[7:0]]     <= sram.o_SRAM_DQ;
            written[sram.o_SRAM_ADDR[7:0]] <= 1'b1;
            wr_total <= wr_total + 1;
            we_cyc   <= cyc;
            we_run   <= we_run + 1;
            if (sram.o_SRAM_DQ_OE !== 1'b1) bad_strobe <= bad_strobe + 1;
        end else if (we_run != 0) begin
            last_we_len <= we_run;
            we_run      <= 0;
        end
        if (sram.o_SRAM_DQ_OE === 1'b1) oe_run <= oe_run + 1;
        else if (oe_run != 0) begin
            last_oe_len <= oe_run;
            oe_run      <= 0;
        end
        if (done === 1'b1) begin
            done_cnt   <= done_cnt + 1;
            done_cyc   <= cyc;
            wr_at_done <= wr_total;
            if (busy !== 1'b0) bad_done <= bad_done + 1;
        end
    end

    // ---------------- take-level reference model ----------------
    logic [15:0] exp_q [$];
    bit          m_busy = 1'b0, m_paused = 1'b0;
    int unsigned wr_base = 0, done_base = 0;

    task automatic model_start();
        if (!m_busy) begin
            exp_q.delete();
            m_busy    = 1'b1;
            m_paused  = 1'b0;
            wr_base   = wr_total;
            done_base = done_cnt;
        end
    endtask

    task automatic model_frame(input logic [15:0] s, input bit full);
        if (m_busy && !m_paused && full) begin
            exp_q.push_back(s);
            if (exp_q.size() == int'(c_REC_LEN)) m_busy = 1'b0;
        end
    endtask

    task automatic model_pause();
        if (m_busy) m_paused = !m_paused;
    endtask

    task automatic model_stop();
        m_busy = 1'b0;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_take(input string tag);
        chk({tag, "_rec_len"}, 32'(rec_len), 32'(exp_q.size()));
        chk({tag, "_writes"}, wr_total - wr_base, 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_mem%0d", tag, i), 32'(mem[i[7:0]]), 32'(exp_q[i]));
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive_bit(input logic l, input logic d, input int ctl);
        bclk = 1'b0;
        lrck = l;
        dat  = d;
        if (ctl == 1) begin
            pause = 1'b1; #10; pause = 1'b0; #30;
        end else if (ctl == 2) begin
            stop = 1'b1; #10; stop = 1'b0; #30;
        end else begin
            #40;
        end
        bclk = 1'b1;
        #40;
    endtask

    // Left half: slot 0 is the I2S delay bit, slots 1..16 carry the sample MSB first
    task automatic send_frame(input logic [15:0] left, input int left_slots,
                              input int ctl_slot, input int ctl);
        for (int s = 0; s < left_slots; s++)
            drive_bit(1'b0, (s >= 1 && s <= 16) ? left[16-s] : 1'($urandom),
                      (s == ctl_slot) ? ctl : 0);
        for (int s = 0; s < 24; s++)
            drive_bit(1'b1, 1'($urandom), 0);
    endtask

    task automatic pulse(input int kind);
        if (kind == 0)      start = 1'b1;
        else if (kind == 1) pause = 1'b1;
        else                stop  = 1'b1;
        #10;
        start = 1'b0; pause = 1'b0; stop = 1'b0;
        #10;
    endtask

    task automatic wait_strobe(output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 1000 && !seen; k++) begin
            @(negedge clk);
            if (sram.o_SRAM_WE_N === 1'b0) seen = 1'b1;
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [15:0] s;
        bit          seen;

        rst_n = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
        bclk = 1'b1; lrck = 1'b1; dat = 1'b0;
        #40;
        chk("rst_async_we_n", 32'(sram.o_SRAM_WE_N), 1);
        rst_n = 1'b1;
        #20;

        chk("rst_addr",  32'(sram.o_SRAM_ADDR), 0);
        chk("rst_dq",    32'(sram.o_SRAM_DQ), 0);
        chk("rst_dq_oe", 32'(sram.o_SRAM_DQ_OE), 0);
        chk("rst_we_n",  32'(sram.o_SRAM_WE_N), 1);
        chk("rst_ce_n",  32'(sram.o_SRAM_CE_N), 0);
        chk("rst_oe_n",  32'(sram.o_SRAM_OE_N), 1);
        chk("rst_lb_ub", 32'({sram.o_SRAM_LB_N, sram.o_SRAM_UB_N}), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_done",  32'(done), 0);
        chk("rst_len",   32'(rec_len), 0);

        // Basic take with fixed samples
        pulse(0); model_start();
        chk("t1_busy", 32'(busy), 1);
        send_frame(16'h8001, 24, -1, 0); model_frame(16'h8001, 1'b1);
        send_frame(16'h7FFE, 24, -1, 0); model_frame(16'h7FFE, 1'b1);
        send_frame(16'h1234, 24, -1, 0); model_frame(16'h1234, 1'b1);
        check_take("t1");
        chk("t1_we_low_cycles", last_we_len, 1);
        chk("t1_oe_cycles",     last_oe_len, 3);
        chk("t1_strobe_oe",     bad_strobe, 0);
        pulse(2); model_stop();
        repeat (2) @(negedge clk);
        chk("t1_done_pulses", done_cnt - done_base, 1);
        chk("t1_busy_end",    32'(busy), 0);
        chk("t1_len_hold",    32'(rec_len), 3);

        // Take length limit with random samples
        pulse(0); model_start();
        for (int f = 0; f < 6; f++) begin
            s = 16'($urandom);
            send_frame(s, 24, -1, 0);
            model_frame(s, 1'b1);
        end
        check_take("t2");
        chk("t2_busy",         32'(busy), 0);
        chk("t2_done_pulses",  done_cnt - done_base, 1);
        chk("t2_writes_at_done", wr_at_done - wr_base, 32'(c_REC_LEN));
        chk("t2_done_after_w", done_cyc - we_cyc, 2);
        chk("t2_no_addr4",     32'(written[4]), 0);
        chk("t2_done_busy",    bad_done, 0);

        // Pause mid-shift, hold, resume
        pulse(0); model_start();
        s = 16'($urandom); send_frame(s, 24, -1, 0); model_frame(s, 1'b1);
        s = 16'($urandom); model_pause(); send_frame(s, 24, 8, 1); model_frame(s, 1'b0);
        for (int f = 0; f < 3; f++) begin
            s = 16'($urandom);
            send_frame(s, 24, -1, 0);
            model_frame(s, 1'b1);
        end
        chk("t3_busy_paused", 32'(busy), 1);
        pulse(1); model_pause();
        s = 16'($urandom); send_frame(s, 24, -1, 0); model_frame(s, 1'b1);
        check_take("t3");
        pulse(2); model_stop();
        repeat (2) @(negedge clk);

        // Stop during the strobe cycle
        pulse(0); model_start();
        s = 16'($urandom);
        fork
            send_frame(s, 24, -1, 0);
            begin
                wait_strobe(seen);
                if (seen) begin
                    stop = 1'b1; #10; stop = 1'b0;
                end
            end
        join
        model_frame(s, 1'b1); model_stop();
        chk("t4_strobe_seen", 32'(seen), 1);
        check_take("t4");
        chk("t4_done_pulses",  done_cnt - done_base, 1);
        chk("t4_done_after_w", done_cyc - we_cyc, 2);
        chk("t4_busy",         32'(busy), 0);

        // Stop during shift: nothing written
        pulse(0); model_start();
        s = 16'($urandom); model_stop(); send_frame(s, 24, 8, 2);
        check_take("t4b");
        chk("t4b_done_pulses", done_cnt - done_base, 1);

        // Short frame, then start while busy
        pulse(0); model_start();
        s = 16'($urandom); send_frame(s, 24, -1, 0); model_frame(s, 1'b1);
        s = 16'($urandom); send_frame(s, 11, -1, 0); model_frame(s, 1'b0);
        pulse(0); model_start();
        s = 16'($urandom); send_frame(s, 24, -1, 0); model_frame(s, 1'b1);
        check_take("t5");
        chk("t5_addr", 32'(sram.o_SRAM_ADDR), 2);
        pulse(2); model_stop();
        repeat (2) @(negedge clk);

        // Reset asserted during the strobe cycle
        pulse(0); model_start();
        s = 16'($urandom);
        fork
            send_frame(s, 24, -1, 0);
            begin
                wait_strobe(seen);
                if (seen) begin
                    #1 rst_n = 1'b0;
                    #2;
                    chk("t6_async_we_n",  32'(sram.o_SRAM_WE_N), 1);
                    chk("t6_async_dq_oe", 32'(sram.o_SRAM_DQ_OE), 0);
                end
            end
        join
        chk("t6_strobe_seen", 32'(seen), 1);
        model_stop();
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_len",  32'(rec_len), 0);
        chk("t6_addr", 32'(sram.o_SRAM_ADDR), 0);
        chk("t6_done", 32'(done), 0);

        pulse(0); model_start();
        s = 16'($urandom); send_frame(s, 24, -1, 0); model_frame(s, 1'b1);
        check_take("t6b");
        pulse(2); model_stop();
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
